fsk_phase_gen: RTL and testbench
================================

# fsk_phase_gen

Continuous-phase FSK phase generator for the BLE modulator. Accepts data bits over a valid/ready handshake and, for each bit, emits exactly `SAMPLES_PER_SYM` phase samples. Each sample comes from an accumulator that advances by the tone increment selected by the bit. The `phase` output feeds the sine lookup stage directly: a `PHASE_RES`-bit index, one sample per enabled clock.

## Interface
- `PHASE_RES`, 3: width of the `phase` output; equals the sine lookup index width.
- `ACC_W`, 16: phase accumulator width; `phase` is `acc[ACC_W-1 -: PHASE_RES]`.
- `SAMPLES_PER_SYM`, 8: phase samples per data bit; must be ≥ 2.
- `INC_F0`, 16'h1000: accumulator increment per sample for bit 0.
- `INC_F1`, 16'h2000: accumulator increment per sample for bit 1.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `en` in, 1: sample enable; low freezes all state.
- `bit_in` in, 1: data bit; qualified by `bit_valid`.
- `bit_valid` in, 1: upstream offers `bit_in`.
- `bit_ready` out, 1: block accepts `bit_in` this cycle; combinational.
- `phase` out, `PHASE_RES`: registered phase index to the sine lookup.
- `phase_valid` out, 1: registered; `phase` is a new sample this cycle.
- `sym_strobe` out, 1: registered; high on the first sample of each symbol.
- `busy` out, 1: high while in RUN.

## Operation
- FSM has two states: IDLE and RUN. Reset state is IDLE.
- Handshake: a bit is taken on a rising edge where `bit_valid && bit_ready`.
- `bit_ready = rst_n && en && (state==IDLE || (state==RUN && cnt==SAMPLES_PER_SYM-1))`.
- IDLE, on accept: latch `bit_in` into `cur_bit`, set `cnt=0`, go to RUN, and perform the first accumulator update in the same edge.
- RUN, per enabled cycle:
  - `acc <= acc + (cur_bit ? INC_F1 : INC_F0)`, modulo 2^`ACC_W` (wrap silently).
  - `phase <= top PHASE_RES bits of the new acc`.
  - `phase_valid <= 1`.
  - `cnt` increments.
- End of symbol: at `cnt==SAMPLES_PER_SYM-1`:
  - Bit accepted: latch it, reset `cnt` to 0, stay in RUN. The next sample uses the new increment, with no gap cycle.
  - No bit offered: return to IDLE. The next cycle has `phase_valid=0`.
- Phase continuity: `acc` is never cleared except by reset. IDLE holds `acc` and `phase`, so the next burst resumes from the held phase.
- `en` low: `acc`, `cnt`, `cur_bit`, the state and `phase` all hold. `phase_valid=0` and `sym_strobe=0` in that cycle, and `bit_ready=0`.
- `sym_strobe` is high with the first `phase_valid` sample of every accepted bit.

## Timing
- Reset values:
  - `acc=0`, `phase=0`, `phase_valid=0`, `sym_strobe=0`, `busy=0`, `cnt=0`, `cur_bit=0`, state IDLE.
  - `bit_ready=0` while `rst_n` is low.
- Latency: a bit accepted at edge T gives its first `phase_valid` in the cycle after T. The last sample is at T+`SAMPLES_PER_SYM`-1, in enabled cycles.
- Back-to-back bits give a continuous `phase_valid`: N bits produce N×`SAMPLES_PER_SYM` contiguous samples when `en` is held high.
- Simultaneous `en` low and `bit_valid`: the bit is not accepted, and upstream must hold it.
- Reset asserted mid-symbol: all state returns to its reset values immediately. The partial symbol is discarded and no further samples are emitted.

## Structure
- The shared defines header holds `phaseRes` (=3) and `SinSize` (=13). `PHASE_RES` defaults from `phaseRes`, and the increment defaults live alongside it.
- One natural sub-module, `fsk_phase_acc`, covers the accumulator plus increment mux and phase extraction, with inputs `en_step` and `sel`. The FSM, counter and handshake stay in the top.

## Test plan
- Reset, then send bit 1 → `phase` = 1,2,3,4,5,6,7,0 on 8 consecutive `phase_valid` cycles; `sym_strobe` is high on the first of these; `acc` ends at 0 (wrap).
- From reset, send bit 0 → `phase` = 0,1,1,2,2,3,3,4; the block then returns to IDLE, `phase_valid=0`, and `phase` holds at 4.
- Bits 1,0 back-to-back with `bit_valid` held → 16 contiguous valid samples: 1..7,0, then 0,1,1,2,2,3,3,4. `bit_ready` is high only in IDLE and in the last-sample cycles, and `sym_strobe` pulses twice.
- Bit 1 with `en` low for 3 cycles after the 3rd sample → the samples are unchanged (1..7,0). `phase_valid=0` and `phase` holds at 3 during the stall, and `bit_ready=0`.
- Reset pulsed after the 5th sample of a bit-1 symbol → `phase=0`, `phase_valid=0`, `busy=0` immediately; the next bit 1 restarts at `phase` 1.
- Phase continuity: bit 0, idle 4 cycles, then bit 0 → the second burst is 4,5,5,6,6,7,7,0, continuing from `acc`=0x8000.

Source files
------------

// File: rtl/fsk_phase_gen_pkg.sv
// Shared constants and types for the continuous-phase FSK phase generator.
package fsk_phase_gen_pkg;

    localparam int unsigned phaseRes    = 3;
    localparam int unsigned SinSize     = 13;
    localparam int unsigned AccWDefault = 16;

    localparam logic [15:0] IncF0Default = 16'h1000;
    localparam logic [15:0] IncF1Default = 16'h2000;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } fsk_state_e;

endpackage

// File: rtl/fsk_phase_gen_if.sv
// Bit-in handshake plus phase-sample output bundle of the FSK phase generator.
interface fsk_phase_gen_if
    import fsk_phase_gen_pkg::*;
#(
    parameter int unsigned PHASE_RES = phaseRes
);

    logic                 en;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 bit_ready;
    logic [PHASE_RES-1:0] phase;
    logic                 phase_valid;
    logic                 sym_strobe;
    logic                 busy;

    modport master (
        output en, bit_in, bit_valid,
        input  bit_ready, phase, phase_valid, sym_strobe, busy
    );

    modport slave (
        input  en, bit_in, bit_valid,
        output bit_ready, phase, phase_valid, sym_strobe, busy
    );

endinterface

// File: rtl/fsk_phase_acc.sv
// Phase accumulator with tone-increment mux; phase index is the top bits of the updated sum.
module fsk_phase_acc
    import fsk_phase_gen_pkg::*;
#(
    parameter int unsigned      PHASE_RES = phaseRes,
    parameter int unsigned      ACC_W     = AccWDefault,
    parameter logic [ACC_W-1:0] INC_F0    = IncF0Default,
    parameter logic [ACC_W-1:0] INC_F1    = IncF1Default
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en_step,
    input  logic                 i_sel,
    output logic [PHASE_RES-1:0] o_phase
);

    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     w_acc_next;
    logic [PHASE_RES-1:0] r_phase;

    // Modulo-2^ACC_W wrap is the intended phase behaviour.
    assign w_acc_next = r_acc + (i_sel ? INC_F1 : INC_F0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_phase <= '0;
        end else if (i_en_step) begin
            r_acc   <= w_acc_next;
            r_phase <= w_acc_next[ACC_W-1 -: PHASE_RES];
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/fsk_phase_gen.sv
// FSK phase generator top: IDLE/RUN FSM, per-symbol sample counter and bit handshake.
module fsk_phase_gen
    import fsk_phase_gen_pkg::*;
#(
    parameter int unsigned      PHASE_RES       = phaseRes,
    parameter int unsigned      ACC_W           = AccWDefault,
    parameter int unsigned      SAMPLES_PER_SYM = 8,
    parameter logic [ACC_W-1:0] INC_F0          = IncF0Default,
    parameter logic [ACC_W-1:0] INC_F1          = IncF1Default
) (
    input logic            clk,
    input logic            rst_n,
    fsk_phase_gen_if.slave bus
);

    localparam int unsigned     CntW    = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(SAMPLES_PER_SYM - 1);

    fsk_state_e           r_state;
    fsk_state_e           w_state_next;
    logic [CntW-1:0]      r_cnt;
    logic [CntW-1:0]      w_cnt_next;
    logic                 r_cur_bit;
    logic                 w_cur_bit_next;
    logic                 r_phase_valid;
    logic                 w_phase_valid_next;
    logic                 r_sym_strobe;
    logic                 w_sym_strobe_next;
    logic                 w_last;
    logic                 w_bit_ready;
    logic                 w_take;
    logic                 w_en_step;
    logic                 w_sel;
    logic [PHASE_RES-1:0] w_phase;

    assign w_last      = (r_cnt == LastCnt);
    assign w_bit_ready = rst_n && bus.en && ((r_state == StIdle) || w_last);
    assign w_take      = bus.bit_valid && w_bit_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_cur_bit     <= 1'b0;
            r_phase_valid <= 1'b0;
            r_sym_strobe  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_cur_bit     <= w_cur_bit_next;
            r_phase_valid <= w_phase_valid_next;
            r_sym_strobe  <= w_sym_strobe_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_cur_bit_next     = r_cur_bit;
        w_phase_valid_next = 1'b0;
        w_sym_strobe_next  = 1'b0;
        w_en_step          = 1'b0;
        w_sel              = r_cur_bit;
        if (bus.en) begin
            unique case (r_state)
                StIdle: begin
                    if (w_take) begin
                        w_state_next       = StRun;
                        w_cnt_next         = '0;
                        w_cur_bit_next     = bus.bit_in;
                        w_sel              = bus.bit_in;
                        w_en_step          = 1'b1;
                        w_phase_valid_next = 1'b1;
                        w_sym_strobe_next  = 1'b1;
                    end
                end
                StRun: begin
                    if (!w_last) begin
                        w_cnt_next         = r_cnt + CntW'(1);
                        w_en_step          = 1'b1;
                        w_phase_valid_next = 1'b1;
                    end else if (w_take) begin
                        // Next symbol starts on this edge so the sample stream has no gap.
                        w_cnt_next         = '0;
                        w_cur_bit_next     = bus.bit_in;
                        w_sel              = bus.bit_in;
                        w_en_step          = 1'b1;
                        w_phase_valid_next = 1'b1;
                        w_sym_strobe_next  = 1'b1;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    fsk_phase_acc #(
        .PHASE_RES (PHASE_RES),
        .ACC_W     (ACC_W),
        .INC_F0    (INC_F0),
        .INC_F1    (INC_F1)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en_step (w_en_step),
        .i_sel     (w_sel),
        .o_phase   (w_phase)
    );

    assign bus.bit_ready   = w_bit_ready;
    assign bus.phase       = w_phase;
    assign bus.phase_valid = r_phase_valid;
    assign bus.sym_strobe  = r_sym_strobe;
    assign bus.busy        = (r_state == StRun);

endmodule

// File: tb/tb_fsk_phase_gen.sv
// Bench for fsk_phase_gen: directed scenarios plus random bursts against a sample-counting model.
module tb_fsk_phase_gen;

    localparam int SPS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fsk_phase_gen_if #(.PHASE_RES(3)) bus ();

    fsk_phase_gen #(
        .PHASE_RES       (3),
        .ACC_W           (16),
        .SAMPLES_PER_SYM (SPS),
        .INC_F0          (16'h1000),
        .INC_F1          (16'h2000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: accepted bits owe SPS samples each; acc advances by the bit's tone per sample.
    int unsigned m_acc;
    int unsigned m_pending;
    logic        m_bit;
    logic        m_pv;
    logic        m_ss;
    logic        m_busy;
    logic [2:0]  m_phase;

    int   got[$];
    int   obs_strobes;
    logic q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc     = 0;
        m_pending = 0;
        m_bit     = 1'b0;
        m_pv      = 1'b0;
        m_ss      = 1'b0;
        m_busy    = 1'b0;
        m_phase   = 3'd0;
    endtask

    // Starts at posedge+1 and returns at the next posedge+1.
    task automatic cycle(input logic en_v, input logic valid_v, input logic bit_v,
                         output logic took);
        logic rdy_exp;
        bus.en        = en_v;
        bus.bit_valid = valid_v;
        bus.bit_in    = bit_v;
        #1;
        rdy_exp = en_v && (m_pending == 0);
        chk("bit_ready", 32'(bus.bit_ready), 32'(rdy_exp));
        took = valid_v && rdy_exp;
        @(posedge clk);
        if (en_v) begin
            if (took) begin
                m_pending += SPS;
                m_bit = bit_v;
            end
            if (m_pending > 0) begin
                m_acc = (m_acc + (m_bit ? 32'h2000 : 32'h1000)) % 32'd65536;
                m_pending--;
                m_phase = 3'(m_acc >> 13);
                m_pv    = 1'b1;
                m_ss    = took;
                m_busy  = 1'b1;
            end else begin
                m_pv   = 1'b0;
                m_ss   = 1'b0;
                m_busy = 1'b0;
            end
        end else begin
            m_pv = 1'b0;
            m_ss = 1'b0;
        end
        #1;
        chk("phase_valid", 32'(bus.phase_valid), 32'(m_pv));
        chk("phase", 32'(bus.phase), 32'(m_phase));
        chk("sym_strobe", 32'(bus.sym_strobe), 32'(m_ss));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        if (bus.phase_valid === 1'b1) got.push_back(int'(bus.phase));
        if (bus.sym_strobe === 1'b1) obs_strobes++;
    endtask

    // Offers the bits in q back-to-back, then runs until the block is idle again.
    task automatic send(input int stall_after, input int stall_len, input bit rand_en);
        int   idx     = 0;
        int   stalled = 0;
        int   n       = 0;
        logic took;
        logic en_v;
        got.delete();
        obs_strobes = 0;
        do begin
            en_v = 1'b1;
            if (rand_en) begin
                en_v = ($urandom_range(0, 3) != 0);
            end else if (got.size() == stall_after && stalled < stall_len) begin
                en_v = 1'b0;
                stalled++;
            end
            cycle(en_v, idx < q.size(), (idx < q.size()) ? q[idx] : 1'b0, took);
            if (took) idx++;
            n++;
        end while ((idx < q.size() || m_busy) && n < 400);
        chk("send_done", 32'(n < 400), 32'd1);
    endtask

    task automatic check_seq(input string tag, input int e[8], input int off);
        for (int i = 0; i < 8; i++) begin
            chk(tag, (off + i < got.size()) ? 32'(got[off + i]) : 32'hFFFF_FFFF, 32'(e[i]));
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.en        = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        #1;
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_phase_valid", 32'(bus.phase_valid), 32'd0);
        chk("rst_sym_strobe", 32'(bus.sym_strobe), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_bit_ready", 32'(bus.bit_ready), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        rst_n         = 1'b1;
    endtask

    int   e_one[8]  = '{1, 2, 3, 4, 5, 6, 7, 0};
    int   e_zero[8] = '{0, 1, 1, 2, 2, 3, 3, 4};
    int   e_cont[8] = '{4, 5, 5, 6, 6, 7, 7, 0};
    logic took;

    initial begin
        bus.en        = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        #1;
        do_reset();

        // Single bit 1 wraps through all eight phases back to 0.
        q = {};
        q.push_back(1'b1);
        send(-1, 0, 1'b0);
        chk("b1_count", 32'(got.size()), 32'd8);
        check_seq("b1_seq", e_one, 0);
        chk("b1_strobes", 32'(obs_strobes), 32'd1);

        // Single bit 0 from reset, then phase holds in IDLE.
        do_reset();
        q = {};
        q.push_back(1'b0);
        send(-1, 0, 1'b0);
        check_seq("b0_seq", e_zero, 0);
        cycle(1'b1, 1'b0, 1'b0, took);
        chk("b0_hold", 32'(bus.phase), 32'd4);

        // Back-to-back 1,0 gives 16 contiguous samples.
        do_reset();
        q = {};
        q.push_back(1'b1);
        q.push_back(1'b0);
        send(-1, 0, 1'b0);
        chk("b2b_count", 32'(got.size()), 32'd16);
        check_seq("b2b_first", e_one, 0);
        check_seq("b2b_second", e_zero, 8);
        chk("b2b_strobes", 32'(obs_strobes), 32'd2);

        // Enable stall after the third sample leaves the sequence unchanged.
        do_reset();
        q = {};
        q.push_back(1'b1);
        send(3, 3, 1'b0);
        check_seq("stall_seq", e_one, 0);

        // Enable low in IDLE with a bit offered: not accepted.
        cycle(1'b0, 1'b1, 1'b1, took);
        chk("en_low_no_accept", 32'(bus.busy), 32'd0);

        // Reset mid-symbol discards the partial symbol.
        do_reset();
        got.delete();
        cycle(1'b1, 1'b1, 1'b1, took);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, took);
        chk("mid_count", 32'(got.size()), 32'd5);
        do_reset();
        q = {};
        q.push_back(1'b1);
        send(-1, 0, 1'b0);
        check_seq("after_rst_seq", e_one, 0);

        // Phase continuity across an idle gap.
        do_reset();
        q = {};
        q.push_back(1'b0);
        send(-1, 0, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, took);
        send(-1, 0, 1'b0);
        check_seq("cont_seq", e_cont, 0);

        // Random bursts with random enable gaps.
        repeat (30) begin
            q = {};
            repeat ($urandom_range(1, 3)) q.push_back(1'($urandom_range(0, 1)));
            send(-1, 0, 1'($urandom_range(0, 1)));
            chk("rand_count", 32'(got.size()), 32'(q.size() * SPS));
            repeat ($urandom_range(0, 3)) begin
                cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, took);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
